// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB-Lite types and the byte-lane strobe / transfer-legality helpers
// used by the slave memory.
package ahb_slave_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Little-endian lane strobe for a legal size/offset pair.
    function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (hsize)
            HSIZE_BYTE: be[addr] = 1'b1;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic xfer_err(input logic [2:0] hsize, input logic [1:0] addr);
        return (hsize > HSIZE_WORD)
            || ((hsize == HSIZE_HALF) && addr[0])
            || ((hsize == HSIZE_WORD) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master (router port) and the slave memory.
interface ahb_slave_mem_if;
    import ahb_slave_mem_pkg::*;

    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hsel;
    logic        hready_in;
    logic        hready;
    logic [1:0]  hresp;

    modport slave (
        input  haddr, hwdata, hwrite, htrans, hsize, hburst, hsel, hready_in,
        output hrdata, hready, hresp
    );

    modport master (
        output haddr, hwdata, hwrite, htrans, hsize, hburst, hsel, hready_in,
        input  hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_slave_mem_ram.sv
// Word-wide RAM with per-byte write strobes: synchronous write, combinational read.
module ahb_slave_mem_ram #(
    parameter int addr_w = 14
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [addr_w-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**addr_w];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory with two-cycle ERROR response; optional fixed wait
// states are built only when AHB_SLV_MEM_WAIT_EN is defined.
module ahb_slave_mem
    import ahb_slave_mem_pkg::*;
#(
    parameter int addr_w = 14,
    parameter int wait_c = 2
) (
    input  logic i_hclk,
    input  logic i_hreset,
    ahb_slave_mem_if.slave s_bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
`ifdef AHB_SLV_MEM_WAIT_EN
        , ST_WAIT
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_acc_state;
    logic [addr_w-1:0] r_addr;
    logic [3:0]        r_be;
    logic              r_write;
    logic              w_accept;
    logic              w_hready;
    hresp_t            w_hresp;
    logic              w_we;
    logic [31:0]       w_rdata;
    logic              w_unused;

`ifdef AHB_SLV_MEM_WAIT_EN
    localparam logic [3:0] CNT_LOAD = 4'(wait_c - 1);
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
`endif

    assign w_unused = ^{s_bus.hburst, s_bus.haddr[31:addr_w+2], s_bus.htrans[0], 4'(wait_c)};

    assign w_accept = s_bus.hsel & s_bus.hready_in & s_bus.htrans[1] & w_hready;

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        case (r_state)
            ST_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = HRESP_ERROR;
            end
            ST_ERR2: w_hresp = HRESP_ERROR;
`ifdef AHB_SLV_MEM_WAIT_EN
            ST_WAIT: w_hready = 1'b0;
`endif
            default: ;
        endcase
    end

    // Where an accepted transfer goes; errors take priority over waits.
    always_comb begin
        w_acc_state = ST_DATA;
`ifdef AHB_SLV_MEM_WAIT_EN
        if (wait_c != 0) w_acc_state = ST_WAIT;
`endif
        if (xfer_err(s_bus.hsize, s_bus.haddr[1:0])) w_acc_state = ST_ERR1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
`ifdef AHB_SLV_MEM_WAIT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            ST_IDLE, ST_ERR2: w_state_nxt = w_accept ? w_acc_state : ST_IDLE;
            ST_DATA: begin
                w_we        = r_write;
                w_state_nxt = w_accept ? w_acc_state : ST_IDLE;
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
`ifdef AHB_SLV_MEM_WAIT_EN
            ST_WAIT: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_DATA;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
`ifdef AHB_SLV_MEM_WAIT_EN
        if (w_accept && (w_acc_state == ST_WAIT)) w_cnt_nxt = CNT_LOAD;
`endif
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
`ifdef AHB_SLV_MEM_WAIT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef AHB_SLV_MEM_WAIT_EN
            r_cnt   <= w_cnt_nxt;
`endif
            if (w_accept) begin
                r_addr  <= s_bus.haddr[addr_w+1:2];
                r_be    <= byte_en(s_bus.hsize, s_bus.haddr[1:0]);
                r_write <= s_bus.hwrite;
            end
        end
    end

    ahb_slave_mem_ram #(.addr_w(addr_w)) u_ram (
        .i_clk   (i_hclk),
        .i_we    (w_we),
        .i_be    (r_be),
        .i_addr  (r_addr),
        .i_wdata (s_bus.hwdata),
        .o_rdata (w_rdata)
    );

    assign s_bus.hrdata = ((r_state == ST_DATA) && !r_write) ? w_rdata : 32'h0;
    assign s_bus.hready = w_hready;
    assign s_bus.hresp  = w_hresp;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem; read data is checked through a scoreboard queue.
module tb_ahb_slave_mem;

    localparam int TMO = 40;
`ifdef AHB_SLV_MEM_WAIT_EN
    localparam int EXP_W = 3;
`else
    localparam int EXP_W = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] sb_q[$];

    ahb_slave_mem_if bus();

    ahb_slave_mem #(.addr_w(14), .wait_c(3)) dut (
        .i_hclk   (clk),
        .i_hreset (rst),
        .s_bus    (bus)
    );

    assign bus.hready_in = bus.hready;

    always #5 clk = ~clk;

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output int waits,
                        output logic [1:0] resp_first, output logic [1:0] resp_last,
                        output logic [31:0] rdata);
        int guard;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = addr;
        bus.hwrite = wr; bus.hsize = size;
        guard = 0;
        @(negedge clk);
        while (!bus.hready && guard < TMO) begin guard++; @(negedge clk); end
        @(posedge clk); #1;
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wdata;
        waits = 0;
        @(negedge clk);
        resp_first = bus.hresp;
        while (!bus.hready && waits < TMO) begin waits++; @(negedge clk); end
        resp_last = bus.hresp;
        rdata = bus.hrdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (bus.hready !== 1'b1) begin n_err++; $display("FAIL reset_hready got %b exp 1", bus.hready); end
        n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL reset_hresp got %b exp 00", bus.hresp); end
        n_cmp++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL reset_hrdata got %h exp 0", bus.hrdata); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_word_rw();
        int w; logic [1:0] r1, r2; logic [31:0] rd, exp;
        xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, w, r1, r2, rd);
        n_cmp++; if (w !== EXP_W) begin n_err++; $display("FAIL word_wr_waits got %0d exp %0d", w, EXP_W); end
        n_cmp++; if (r2 !== 2'b00) begin n_err++; $display("FAIL word_wr_resp got %b exp 00", r2); end
        sb_q.push_back(32'hDEADBEEF);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, w, r1, r2, rd);
        exp = sb_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL word_rd_data got %h exp %h", rd, exp); end
        n_cmp++; if (r2 !== 2'b00) begin n_err++; $display("FAIL word_rd_resp got %b exp 00", r2); end
        n_cmp++; if (w !== EXP_W) begin n_err++; $display("FAIL word_rd_waits got %0d exp %0d", w, EXP_W); end
    endtask

    task automatic test_byte_lanes();
        int w; logic [1:0] r1, r2; logic [31:0] rd, exp;
        xfer(1'b1, 32'h20, 3'd2, 32'h11223344, w, r1, r2, rd);
        xfer(1'b1, 32'h22, 3'd0, 32'h77AA9988, w, r1, r2, rd);
        sb_q.push_back(32'h11AA3344);
        xfer(1'b0, 32'h20, 3'd2, 32'h0, w, r1, r2, rd);
        exp = sb_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL byte_lane2 got %h exp %h", rd, exp); end
        xfer(1'b1, 32'h22, 3'd1, 32'hBBCC6655, w, r1, r2, rd);
        xfer(1'b1, 32'h20, 3'd0, 32'hFFFFFF55, w, r1, r2, rd);
        sb_q.push_back(32'hBBCC3355);
        xfer(1'b0, 32'h20, 3'd2, 32'h0, w, r1, r2, rd);
        exp = sb_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL half_byte_lanes got %h exp %h", rd, exp); end
    endtask

    task automatic test_error();
        int w; logic [1:0] r1, r2; logic [31:0] rd, exp;
        logic [2:0]  sz [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] ad [3] = '{32'h31, 32'h30, 32'h32};
        xfer(1'b1, 32'h30, 3'd2, 32'h12345678, w, r1, r2, rd);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, ad[i], sz[i], 32'hFFFFFFFF, w, r1, r2, rd);
            n_cmp++; if (w !== 1) begin n_err++; $display("FAIL err%0d_lowcycles got %0d exp 1", i, w); end
            n_cmp++; if (r1 !== 2'b01) begin n_err++; $display("FAIL err%0d_resp1 got %b exp 01", i, r1); end
            n_cmp++; if (r2 !== 2'b01) begin n_err++; $display("FAIL err%0d_resp2 got %b exp 01", i, r2); end
        end
        sb_q.push_back(32'h12345678);
        xfer(1'b0, 32'h30, 3'd2, 32'h0, w, r1, r2, rd);
        exp = sb_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL err_unchanged got %h exp %h", rd, exp); end
        n_cmp++; if (r2 !== 2'b00) begin n_err++; $display("FAIL err_after_resp got %b exp 00", r2); end
        xfer(1'b1, 32'h33, 3'd0, 32'hAB000000, w, r1, r2, rd);
        sb_q.push_back(32'hAB345678);
        xfer(1'b0, 32'h30, 3'd2, 32'h0, w, r1, r2, rd);
        exp = sb_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL byte_lane3 got %h exp %h", rd, exp); end
    endtask

`ifdef AHB_SLV_MEM_WAIT_EN
    task automatic test_wait();
        int w; logic [1:0] r1, r2; logic [31:0] rd, exp;
        xfer(1'b1, 32'h40, 3'd2, 32'hCAFEF00D, w, r1, r2, rd);
        sb_q.push_back(32'hCAFEF00D);
        xfer(1'b0, 32'h40, 3'd2, 32'h0, w, r1, r2, rd);
        exp = sb_q.pop_front();
        n_cmp++; if (w !== 3) begin n_err++; $display("FAIL wait_lowcycles got %0d exp 3", w); end
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL wait_rdata got %h exp %h", rd, exp); end
        n_cmp++; if (r1 !== 2'b00) begin n_err++; $display("FAIL wait_resp got %b exp 00", r1); end
    endtask
`endif

    task automatic test_back_to_back();
        int w, guard; logic [1:0] r1, r2; logic [31:0] rd, exp;
        xfer(1'b1, 32'h8, 3'd2, 32'hFFFFFFFF, w, r1, r2, rd);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h8; bus.hwrite = 1'b1; bus.hsize = 3'd2;
        guard = 0;
        @(negedge clk);
        while (!bus.hready && guard < TMO) begin guard++; @(negedge clk); end
        @(posedge clk); #1;
        bus.hwdata = 32'h5; bus.hwrite = 1'b0;
        sb_q.push_back(32'h5);
        w = 0;
        @(negedge clk);
        while (!bus.hready && w < TMO) begin w++; @(negedge clk); end
        n_cmp++; if (w !== EXP_W) begin n_err++; $display("FAIL b2b_wr_waits got %0d exp %0d", w, EXP_W); end
        n_cmp++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL b2b_wr_hrdata got %h exp 0", bus.hrdata); end
        @(posedge clk); #1;
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        w = 0;
        @(negedge clk);
        while (!bus.hready && w < TMO) begin w++; @(negedge clk); end
        exp = sb_q.pop_front();
        n_cmp++; if (w !== EXP_W) begin n_err++; $display("FAIL b2b_rd_waits got %0d exp %0d", w, EXP_W); end
        n_cmp++; if (bus.hrdata !== exp) begin n_err++; $display("FAIL b2b_rd_data got %h exp %h", bus.hrdata, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w, guard; logic [1:0] r1, r2; logic [31:0] rd, exp;
        xfer(1'b1, 32'h50, 3'd2, 32'h0BADF00D, w, r1, r2, rd);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h50; bus.hwrite = 1'b1; bus.hsize = 3'd2;
        guard = 0;
        @(negedge clk);
        while (!bus.hready && guard < TMO) begin guard++; @(negedge clk); end
        @(posedge clk); #1;
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'h600DCAFE;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.hready !== 1'b1) begin n_err++; $display("FAIL rstmid_hready got %b exp 1", bus.hready); end
        n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL rstmid_hresp got %b exp 00", bus.hresp); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        sb_q.push_back(32'h0BADF00D);
        xfer(1'b0, 32'h50, 3'd2, 32'h0, w, r1, r2, rd);
        exp = sb_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rstmid_dropped got %h exp %h", rd, exp); end
    endtask

    initial begin
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 32'h0; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.hburst = 3'd0; bus.hwdata = 32'h0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_error();
`ifdef AHB_SLV_MEM_WAIT_EN
        test_wait();
`endif
        test_back_to_back();
        test_reset_mid();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got %0d exp 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
